// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
//   Snake movement and body tracking. On each step pulse the head advances one
//   grid cell in the latched direction and the body shifts behind it. The body
//   grows when addLength was seen since the last step or arrives with the step.
//   Wall hits and self hits move the FSM to DEAD, which only reset leaves.
//
// Optional feature:
//   SNAKE_WRAP_EN  defined   -> walls wrap around to the opposite edge
//                  undefined -> a wall hit kills the snake
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   step           one-cycle advance pulse
//   dir_req[1:0]   00 up, 01 down, 10 left, 11 right
//   dir_valid      qualifies dir_req
//   addLength      growth pulse from the food block
//   headX/headY    registered head coordinate (segment 0)
//   length         registered segment count
//   game_over      high in DEAD
//   qX/qY          occupancy query cell
//   qHit           any live segment sits on (qX,qY)
//   qHead          the head sits on (qX,qY)
//
// States:
//   ST_RUN  | snake alive, steps are executed
//   ST_DEAD | body frozen, inputs ignored until reset

module snake_body_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 20,
  parameter int INIT_Y   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [1:0] dir_req,
  input  logic       dir_valid,
  input  logic       addLength,
  output logic [5:0] headX,
  output logic [5:0] headY,
  output logic [4:0] length,
  output logic       game_over,
  input  logic [5:0] qX,
  input  logic [5:0] qY,
  output logic       qHit,
  output logic       qHead
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [5:0] X_MAX    = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX    = 6'(GRID_H - 1);
  localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
  localparam logic [4:0] LEN_INIT = 5'(INIT_LEN);

  logic [5:0] seg_x_q [MAX_LEN];
  logic [5:0] seg_y_q [MAX_LEN];
  logic [5:0] seg_x_d [MAX_LEN];
  logic [5:0] seg_y_d [MAX_LEN];
  logic [4:0] len_q, len_d;
  logic [1:0] cur_dir_q, cur_dir_d;
  logic [1:0] req_dir_q, req_dir_d;
  logic       grow_pend_q, grow_pend_d;
  logic [0:0] state_q, state_d;

  logic       grow;
  logic       at_edge;
  logic       wall_hit;
  logic       self_hit;
  logic [5:0] nx, ny;
  logic [4:0] hit_limit;
  logic [1:0] ref_dir;

  assign grow = grow_pend_q | addLength;

  // Next head position. The edge test is made before any arithmetic so a
  // wrapped or killed move never stores an underflowed coordinate.
  always_comb begin
    nx      = seg_x_q[0];
    ny      = seg_y_q[0];
    at_edge = 1'b0;
    case (req_dir_q)
      DIR_UP: begin
        at_edge = (seg_y_q[0] == 6'd0);
        ny      = at_edge ? Y_MAX : seg_y_q[0] - 6'd1;
      end
      DIR_DOWN: begin
        at_edge = (seg_y_q[0] == Y_MAX);
        ny      = at_edge ? 6'd0 : seg_y_q[0] + 6'd1;
      end
      DIR_LEFT: begin
        at_edge = (seg_x_q[0] == 6'd0);
        nx      = at_edge ? X_MAX : seg_x_q[0] - 6'd1;
      end
      default: begin
        at_edge = (seg_x_q[0] == X_MAX);
        nx      = at_edge ? 6'd0 : seg_x_q[0] + 6'd1;
      end
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
`else
    wall_hit = at_edge;
`endif
  end

  // Without growth the tail cell is vacated by this step, so it is excluded.
  always_comb begin
    hit_limit = grow ? len_q : len_q - 5'd1;
    self_hit  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < hit_limit) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny))
        self_hit = 1'b1;
    end
  end

  // A request arriving with a step is judged against the direction that step
  // applies, since that becomes cur_dir on the same edge.
  assign ref_dir = step ? req_dir_q : cur_dir_q;

  always_comb begin
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    cur_dir_d   = cur_dir_q;
    req_dir_d   = req_dir_q;
    grow_pend_d = grow_pend_q;
    state_d     = state_q;
    if (state_q == ST_RUN) begin
      if (dir_valid && (dir_req != {ref_dir[1], ~ref_dir[0]}))
        req_dir_d = dir_req;
      if (addLength)
        grow_pend_d = 1'b1;
      if (step) begin
        grow_pend_d = 1'b0;
        if (wall_hit || self_hit) begin
          state_d = ST_DEAD;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nx;
          seg_y_d[0] = ny;
          if (grow && (len_q < LEN_MAX))
            len_d = len_q + 5'd1;
          cur_dir_d = req_dir_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? 6'(INIT_X - i) : 6'd0;
        seg_y_q[i] <= (i < INIT_LEN) ? 6'(INIT_Y) : 6'd0;
      end
      len_q       <= LEN_INIT;
      cur_dir_q   <= DIR_RIGHT;
      req_dir_q   <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      cur_dir_q   <= cur_dir_d;
      req_dir_q   <= req_dir_d;
      grow_pend_q <= grow_pend_d;
      state_q     <= state_d;
    end
  end

  assign headX     = seg_x_q[0];
  assign headY     = seg_y_q[0];
  assign length    = len_q;
  assign game_over = (state_q == ST_DEAD);

  always_comb begin
    qHit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (seg_x_q[i] == qX) && (seg_y_q[i] == qY))
        qHit = 1'b1;
    end
  end

  assign qHead = (seg_x_q[0] == qX) && (seg_y_q[0] == qY);

endmodule

// File: tb/tb_snake_body_ctrl.sv
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [1:0] dir_req;
  logic       dir_valid;
  logic       addLength;
  logic [5:0] headX, headY;
  logic [4:0] length;
  logic       game_over;
  logic [5:0] qX, qY;
  logic       qHit, qHead;

  always #5 clk = ~clk;

  snake_body_ctrl dut (
    .clk(clk), .rst(rst), .step(step), .dir_req(dir_req),
    .dir_valid(dir_valid), .addLength(addLength),
    .headX(headX), .headY(headY), .length(length), .game_over(game_over),
    .qX(qX), .qY(qY), .qHit(qHit), .qHead(qHead)
  );

  typedef struct {
    logic       stp;
    logic       dv;
    logic [1:0] dr;
    logic       add;
    logic [5:0] hx;
    logic [5:0] hy;
    logic [4:0] len;
    logic       go;
  } vec_t;

  typedef struct {
    logic [5:0] hx;
    logic [5:0] hy;
    logic [4:0] len;
    logic       go;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[24];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(logic s, logic dv, logic [1:0] dr, logic a,
                              int hx, int hy, int len, logic go);
    vec_t v;
    v.stp = s; v.dv = dv; v.dr = dr; v.add = a;
    v.hx = 6'(hx); v.hy = 6'(hy); v.len = 5'(len); v.go = go;
    return v;
  endfunction

  function automatic exp_t mke(int hx, int hy, int len, logic go);
    exp_t e;
    e.hx = 6'(hx); e.hy = 6'(hy); e.len = 5'(len); e.go = go;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_headX"}, int'(headX), int'(e.hx));
      chk({tag, "_headY"}, int'(headY), int'(e.hy));
      chk({tag, "_length"}, int'(length), int'(e.len));
      chk({tag, "_game_over"}, int'(game_over), int'(e.go));
    end
  endtask

  task automatic drive(logic s, logic dv, logic [1:0] dr, logic a, exp_t e, string tag);
    @(negedge clk);
    step = s; dir_valid = dv; dir_req = dr; addLength = a;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    step = 1'b0; dir_valid = 1'b0; addLength = 1'b0;
    check_out(tag);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    sb.push_back(mke(20, 15, 3, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    check_out(tag);
  endtask

  task automatic qchk(string name, int x, int y, logic exp_hit, logic exp_head);
    qX = 6'(x); qY = 6'(y);
    #1;
    chk({name, "_qHit"}, int'(qHit), int'(exp_hit));
    chk({name, "_qHead"}, int'(qHead), int'(exp_head));
  endtask

  initial begin
    // step dv dir add | headX headY len go
    tbl[0]  = mk(1, 0, 2'b00, 0, 21, 15, 3, 0);
    tbl[1]  = mk(1, 0, 2'b00, 0, 22, 15, 3, 0);
    tbl[2]  = mk(1, 0, 2'b00, 0, 23, 15, 3, 0);
    tbl[3]  = mk(1, 0, 2'b00, 0, 24, 15, 3, 0);
    tbl[4]  = mk(0, 1, 2'b10, 0, 24, 15, 3, 0);  // reverse request dropped
    tbl[5]  = mk(1, 0, 2'b00, 0, 25, 15, 3, 0);
    tbl[6]  = mk(0, 1, 2'b00, 0, 25, 15, 3, 0);  // up
    tbl[7]  = mk(1, 0, 2'b00, 0, 25, 14, 3, 0);
    tbl[8]  = mk(1, 1, 2'b01, 0, 25, 13, 3, 0);  // down with step: reverse, dropped
    tbl[9]  = mk(1, 0, 2'b00, 0, 25, 12, 3, 0);
    tbl[10] = mk(1, 1, 2'b11, 0, 25, 11, 3, 0);  // right with step: next step only
    tbl[11] = mk(1, 0, 2'b00, 0, 26, 11, 3, 0);
    tbl[12] = mk(0, 0, 2'b00, 1, 26, 11, 3, 0);  // pending growth
    tbl[13] = mk(1, 0, 2'b00, 0, 27, 11, 4, 0);
    tbl[14] = mk(1, 0, 2'b00, 0, 28, 11, 4, 0);
    tbl[15] = mk(1, 0, 2'b00, 1, 29, 11, 5, 0);  // coincident growth
    tbl[16] = mk(1, 0, 2'b00, 0, 30, 11, 5, 0);
    tbl[17] = mk(0, 1, 2'b00, 0, 30, 11, 5, 0);
    tbl[18] = mk(1, 0, 2'b00, 0, 30, 10, 5, 0);
    tbl[19] = mk(0, 1, 2'b10, 0, 30, 10, 5, 0);
    tbl[20] = mk(1, 0, 2'b00, 0, 29, 10, 5, 0);
    tbl[21] = mk(0, 1, 2'b01, 0, 29, 10, 5, 0);
    tbl[22] = mk(1, 0, 2'b00, 0, 29, 10, 5, 1);  // self hit on seg3
    tbl[23] = mk(1, 1, 2'b00, 1, 29, 10, 5, 1);  // ignored in DEAD

    rst = 1'b0; step = 1'b0; dir_req = 2'b00; dir_valid = 1'b0;
    addLength = 1'b0; qX = 6'd0; qY = 6'd0;
    repeat (2) @(posedge clk);

    do_reset("reset");
    qchk("rst_tail", 18, 15, 1'b1, 1'b0);
    qchk("rst_past_tail", 17, 15, 1'b0, 1'b0);
    qchk("rst_head", 20, 15, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].stp, tbl[i].dv, tbl[i].dr, tbl[i].add,
            mke(int'(tbl[i].hx), int'(tbl[i].hy), int'(tbl[i].len), tbl[i].go),
            $sformatf("vec%0d", i));
      if (i == 3) begin
        qchk("four_steps_22", 22, 15, 1'b1, 1'b0);
        qchk("four_steps_21", 21, 15, 1'b0, 1'b0);
      end
    end
    qchk("dead_body", 29, 11, 1'b1, 1'b0);
    qchk("dead_gone_tail", 27, 11, 1'b0, 1'b0);

    do_reset("reset_from_dead");

    // Wall run to the right edge.
    for (int k = 1; k <= 19; k++)
      drive(1'b1, 1'b0, 2'b00, 1'b0, mke(20 + k, 15, 3, 1'b0), $sformatf("wall%0d", k));
`ifdef SNAKE_WRAP_EN
    drive(1'b1, 1'b0, 2'b00, 1'b0, mke(0, 15, 3, 1'b0), "wall_wrap");
`else
    drive(1'b1, 1'b0, 2'b00, 1'b0, mke(39, 15, 3, 1'b1), "wall_hit");
`endif

    do_reset("reset_mid");

    // Growth saturation.
    for (int k = 1; k <= 18; k++)
      drive(1'b1, 1'b0, 2'b00, 1'b1, mke(20 + k, 15, (3 + k > 16) ? 16 : 3 + k, 1'b0),
            $sformatf("sat%0d", k));
    qchk("sat_head", 38, 15, 1'b1, 1'b1);
    qchk("sat_tail", 23, 15, 1'b1, 1'b0);
    qchk("sat_past_tail", 22, 15, 1'b0, 1'b0);
    qchk("sat_ahead", 39, 15, 1'b0, 1'b0);
    qchk("sat_other_row", 30, 14, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
